// File: rtl/sdram_port_arbiter.sv
// Round-robin N-port front end for the SDRAM controller bus: one transaction in flight,
// registered ram_* request held until accept, ack timeout completes with an error.
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            clk_ram,
  input  logic                            rst,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] port_wr_i,
  input  logic [NUM_PORTS-1:0]            port_rd_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     port_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]     port_write_data_i,
  output logic [NUM_PORTS-1:0]            port_accept_o,
  output logic [NUM_PORTS-1:0]            port_ack_o,
  output logic [NUM_PORTS-1:0]            port_error_o,
  output logic [NUM_PORTS*DATA_W-1:0]     port_read_data_o,
  output logic [(DATA_W/8)-1:0]           ram_wr_o,
  output logic                            ram_rd_o,
  output logic [ADDR_W-1:0]               ram_addr_o,
  output logic [DATA_W-1:0]               ram_write_data_o,
  input  logic [DATA_W-1:0]               ram_read_data_i,
  input  logic                            ram_accept_i,
  input  logic                            ram_ack_i,
  input  logic                            ram_error_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr;
  logic [PTR_W-1:0]     grant;
  logic                 txn_rd;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_PORTS-1:0] req;
  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     cand;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p] = port_rd_i[p] | (|port_wr_i[p*STRB_W +: STRB_W]);
    end
  end

  // Scan from the farthest candidate down so the port nearest rr+1 is assigned last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = PTR_W'((int'(rr) + i) % NUM_PORTS);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rr               <= PTR_W'(NUM_PORTS - 1);
      grant            <= '0;
      txn_rd           <= 1'b0;
      cnt              <= '0;
      port_accept_o    <= '0;
      port_ack_o       <= '0;
      port_error_o     <= '0;
      port_read_data_o <= '0;
      ram_wr_o         <= '0;
      ram_rd_o         <= 1'b0;
      ram_addr_o       <= '0;
      ram_write_data_o <= '0;
    end else begin
      port_accept_o <= '0;
      port_ack_o    <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ram_wr_o         <= port_wr_i[gnt_idx*STRB_W +: STRB_W];
            ram_rd_o         <= port_rd_i[gnt_idx];
            ram_addr_o       <= port_addr_i[gnt_idx*ADDR_W +: ADDR_W];
            ram_write_data_o <= port_write_data_i[gnt_idx*DATA_W +: DATA_W];
            txn_rd           <= port_rd_i[gnt_idx];
            grant            <= gnt_idx;
            rr               <= gnt_idx;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (ram_accept_i) begin
            ram_wr_o             <= '0;
            ram_rd_o             <= 1'b0;
            port_accept_o[grant] <= 1'b1;
            port_error_o[grant]  <= 1'b0;
            cnt                  <= '0;
            // A same-edge ack completes immediately; its error overrides the accept clear.
            if (ram_ack_i) begin
              port_ack_o[grant]   <= 1'b1;
              port_error_o[grant] <= ram_error_i;
              if (txn_rd) begin
                port_read_data_o[grant*DATA_W +: DATA_W] <= ram_read_data_i;
              end
              state <= IDLE;
            end else begin
              state <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (ram_ack_i) begin
            port_ack_o[grant]   <= 1'b1;
            port_error_o[grant] <= ram_error_i;
            if (txn_rd) begin
              port_read_data_o[grant*DATA_W +: DATA_W] <= ram_read_data_i;
            end
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            port_ack_o[grant]   <= 1'b1;
            port_error_o[grant] <= 1'b1;
            state               <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: expected accept/ack events go into a scoreboard queue
// and a negedge monitor pops and compares them whenever the DUT pulses a port output.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*SW-1:0]  port_wr;
  logic [NP-1:0]     port_rd;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_wdata;
  logic [NP-1:0]     port_accept;
  logic [NP-1:0]     port_ack;
  logic [NP-1:0]     port_error;
  logic [NP*DW-1:0]  port_rdata;
  logic [SW-1:0]     ram_wr;
  logic              ram_rd;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;
  logic              ram_accept;
  logic              ram_ack;
  logic              ram_error;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_ram(clk), .rst(rst),
    .port_wr_i(port_wr), .port_rd_i(port_rd), .port_addr_i(port_addr),
    .port_write_data_i(port_wdata),
    .port_accept_o(port_accept), .port_ack_o(port_ack), .port_error_o(port_error),
    .port_read_data_o(port_rdata),
    .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_addr_o(ram_addr), .ram_write_data_o(ram_wdata),
    .ram_read_data_i(ram_rdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
    .ram_error_i(ram_error)
  );

  typedef struct {
    bit          is_ack;
    int          port;
    bit          err;
    logic [31:0] rdata;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_ack, input int port, input bit err, input logic [31:0] rdata);
    ev_t e;
    e.is_ack = is_ack;
    e.port   = port;
    e.err    = err;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  // Monitor: every pulse on port_accept/port_ack must match the next queued event.
  always @(negedge clk) begin
    if (!rst) begin
      if (port_accept != '0) begin
        check("accept_onehot", 64'($onehot(port_accept)), 64'd1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept: got 0x%0h expected no event", port_accept);
        end else begin
          mon_e = sb.pop_front();
          check("accept_kind", 64'(mon_e.is_ack), 64'd0);
          check("accept_port", 64'(port_accept), 64'(1 << mon_e.port));
        end
      end
      if (port_ack != '0) begin
        check("ack_onehot", 64'($onehot(port_ack)), 64'd1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got 0x%0h expected no event", port_ack);
        end else begin
          mon_e = sb.pop_front();
          check("ack_kind", 64'(mon_e.is_ack), 64'd1);
          check("ack_port", 64'(port_ack), 64'(1 << mon_e.port));
          check("ack_error", 64'(port_error[mon_e.port]), 64'(mon_e.err));
          check("ack_rdata", 64'(port_rdata[mon_e.port*DW +: DW]), 64'(mon_e.rdata));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit rd, input logic [SW-1:0] wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    port_rd[p]             = rd;
    port_wr[p*SW +: SW]    = wr;
    port_addr[p*AW +: AW]  = a;
    port_wdata[p*DW +: DW] = d;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ram_rd || ram_wr != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("ram_req_seen", 64'(ok), 64'd1);
  endtask

  task automatic do_accept();
    ram_accept = 1'b1;
    tick();
    ram_accept = 1'b0;
  endtask

  task automatic do_ack(input logic [DW-1:0] d, input bit err);
    ram_ack   = 1'b1;
    ram_rdata = d;
    ram_error = err;
    tick();
    ram_ack   = 1'b0;
    ram_error = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [NP-1:0]    snap_err;
    logic [NP*DW-1:0] snap_rd;

    rst = 1'b1;
    port_wr = '0; port_rd = '0; port_addr = '0; port_wdata = '0;
    ram_rdata = '0; ram_accept = 1'b0; ram_ack = 1'b0; ram_error = 1'b0;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    repeat (3) tick();
    check("rst_ram_req", {ram_wr, ram_rd}, '0);
    check("rst_ram_addr_data", {ram_addr, ram_wdata}, '0);
    check("rst_port_pulses", {port_accept, port_ack, port_error}, '0);
    check("rst_port_rdata", port_rdata, '0);
    rst = 1'b0;

    // Port 0 read, accept after 2 cycles in ISSUE, ack 3 cycles later
    set_port(0, 1'b1, '0, 32'h100, '0);
    tick();
    check("t1_ram_rd", 64'(ram_rd), 64'd1);
    check("t1_ram_addr", ram_addr, 32'h100);
    check("t1_ram_wr", ram_wr, '0);
    tick();
    check("t1_ram_rd_held", 64'(ram_rd), 64'd1);
    push(1'b0, 0, 1'b0, '0);
    do_accept();
    check("t1_rd_cleared", 64'(ram_rd), 64'd0);
    check("t1_addr_held", ram_addr, 32'h100);
    set_port(0, 1'b0, '0, '0, '0);
    tick();
    tick();
    exp_rd[0] = 32'hDEADBEEF;
    push(1'b1, 0, 1'b0, exp_rd[0]);
    do_ack(32'hDEADBEEF, 1'b0);
    tick();
    check("t1_rdata_held", port_rdata[0 +: DW], 32'hDEADBEEF);

    // Both ports requesting; last grant was port 0, so grants run 1,0,1,0
    set_port(0, 1'b1, '0, 32'hA0, '0);
    set_port(1, 1'b1, '0, 32'hB0, '0);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (k % 2 == 0) ? 1 : 0;
      wait_req();
      check("rr_addr", ram_addr, (p == 1) ? 32'hB0 : 32'hA0);
      push(1'b0, p, 1'b0, '0);
      do_accept();
      exp_rd[p] = 32'h1000 + k;
      push(1'b1, p, 1'b0, exp_rd[p]);
      do_ack(32'h1000 + k, 1'b0);
    end
    set_port(0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, '0, '0, '0);

    // Write held stable for 5 cycles without accept; ack must not touch read data
    set_port(1, 1'b0, 4'b0011, 32'h40, 32'h12345678);
    wait_req();
    check("t3_ram_wr", ram_wr, 4'b0011);
    check("t3_ram_rd", 64'(ram_rd), 64'd0);
    check("t3_ram_addr", ram_addr, 32'h40);
    check("t3_ram_wdata", ram_wdata, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {ram_wr, ram_addr, ram_wdata}, {4'b0011, 32'h40, 32'h12345678});
    end
    push(1'b0, 1, 1'b0, '0);
    do_accept();
    check("t3_wr_cleared", ram_wr, '0);
    check("t3_wdata_held", ram_wdata, 32'h12345678);
    set_port(1, 1'b0, '0, '0, '0);
    push(1'b1, 1, 1'b0, exp_rd[1]);
    do_ack(32'hFFFFFFFF, 1'b0);

    // No ack after accept: timeout ack+err 16 cycles after the accept pulse
    set_port(0, 1'b1, '0, 32'h200, '0);
    wait_req();
    push(1'b0, 0, 1'b0, '0);
    do_accept();
    set_port(0, 1'b0, '0, '0, '0);
    push(1'b1, 0, 1'b1, exp_rd[0]);
    n = 0;
    while (port_ack == '0 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd16);
    tick();
    snap_err = port_error;
    snap_rd  = port_rdata;
    ram_ack = 1'b1; ram_rdata = 32'h55555555; ram_error = 1'b0;
    tick();
    ram_ack = 1'b0;
    tick();
    check("stray_ack_none", port_ack, '0);
    check("stray_err_kept", port_error, snap_err);
    check("stray_rdata_kept", port_rdata, snap_rd);

    // Accept and ack on the same edge with error
    set_port(1, 1'b1, '0, 32'h300, '0);
    wait_req();
    push(1'b0, 1, 1'b0, '0);
    exp_rd[1] = 32'hCAFEF00D;
    push(1'b1, 1, 1'b1, exp_rd[1]);
    ram_accept = 1'b1; ram_ack = 1'b1; ram_error = 1'b1; ram_rdata = 32'hCAFEF00D;
    tick();
    ram_accept = 1'b0; ram_ack = 1'b0; ram_error = 1'b0;
    set_port(1, 1'b0, '0, '0, '0);
    check("t5_together", {port_accept[1], port_ack[1], port_error[1]}, 3'b111);
    // Next accept on port 1 clears its error; port 0 error untouched
    set_port(1, 1'b0, 4'hF, 32'h304, 32'hAAAA5555);
    wait_req();
    push(1'b0, 1, 1'b0, '0);
    do_accept();
    set_port(1, 1'b0, '0, '0, '0);
    check("t5_err1_cleared", 64'(port_error[1]), 64'd0);
    check("t5_err0_kept", 64'(port_error[0]), 64'd1);
    push(1'b1, 1, 1'b0, exp_rd[1]);
    do_ack(32'h0, 1'b0);

    // Reset while waiting for ack
    set_port(1, 1'b1, '0, 32'h400, '0);
    wait_req();
    push(1'b0, 1, 1'b0, '0);
    do_accept();
    set_port(1, 1'b0, '0, '0, '0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ram", {ram_wr, ram_rd, ram_addr, ram_wdata}, '0);
    check("t6_rst_ports", {port_accept, port_ack, port_error}, '0);
    check("t6_rst_rdata", port_rdata, '0);
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, '0, 32'h500, '0);
    set_port(1, 1'b1, '0, 32'h600, '0);
    wait_req();
    check("t6_first_grant", ram_addr, 32'h500);
    push(1'b0, 0, 1'b0, '0);
    do_accept();
    set_port(0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, '0, '0, '0);
    exp_rd[0] = 32'h77;
    push(1'b1, 0, 1'b0, exp_rd[0]);
    do_ack(32'h77, 1'b0);

    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
